// File: rtl/lyr1_mac_sequencer_pkg.sv
// Shared constants, FSM encoding and the Q8.8 shift-and-saturate helper
// for the layer-1 MAC sequencer.
package lyr1_mac_sequencer_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int ACCW = 36;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_OUT   = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

    // Tap index 9 of each neuron's 10-word record is the bias
    localparam logic [3:0] K_BIAS = 4'd9;

    localparam logic signed [ACCW-1:0] SAT_MAX = 36'sd32767;
    localparam logic signed [ACCW-1:0] SAT_MIN = -36'sd32768;

    function automatic logic [DW-1:0] sat_q88(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] shifted;
        shifted = acc >>> FRAC;
        if (shifted > SAT_MAX) begin
            sat_q88 = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            sat_q88 = 16'h8000;
        end else begin
            sat_q88 = shifted[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/lyr1_mac_sequencer_tap_acc.sv
// Registered signed multiply-accumulate; one tap or one bias per cycle.
// The next-state value is exported so results can be registered alongside it.
module lyr1_mac_sequencer_tap_acc
    import lyr1_mac_sequencer_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic                   add_bias_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [ACCW-1:0] acc_nxt_o
);

    logic signed [2*DW-1:0] prod_s;
    logic signed [ACCW-1:0] acc_d;
    logic signed [ACCW-1:0] acc_q;

    // Next accumulator value: clear, tap product, or bias aligned to Q8.8 product scale
    always_comb begin
        prod_s = a_i * b_i;
        acc_d  = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACCW'(prod_s);
        end else if (add_bias_i) begin
            acc_d = acc_q + (ACCW'(b_i) <<< FRAC);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_nxt_o = acc_d;

endmodule

// File: rtl/lyr1_mac_sequencer.sv
// Sequences one shared serial MAC over a 3x3 window for NEURONS neurons,
// fetching weights/bias from external memory and emitting saturated Q8.8 results.
module lyr1_mac_sequencer
    import lyr1_mac_sequencer_pkg::*;
#(
    parameter int NEURONS = 4,
    parameter int AW      = $clog2(NEURONS*10),
    parameter int IW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [9*DW-1:0] x_flat_i,
    output logic            w_en_o,
    output logic [AW-1:0]   w_addr_o,
    input  logic [DW-1:0]   w_data_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [DW-1:0]   res_data_o,
    output logic [IW-1:0]   res_idx_o,
    output logic            busy_o,
    output logic            done_o
);

    state_t            state_q, state_d;
    logic [9*DW-1:0]   x_q, x_d;
    logic [IW-1:0]     n_q, n_d;
    logic [3:0]        k_q, k_d;
    logic              w_en_q, w_en_d;
    logic [AW-1:0]     w_addr_q, w_addr_d;
    logic              rd_vld_q;
    logic [3:0]        rd_k_q;
    logic              res_valid_q, res_valid_d;
    logic [DW-1:0]     res_data_q, res_data_d;
    logic [IW-1:0]     res_idx_q, res_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept_s, handshake_s, last_s, clr_s, tap_en_s, bias_en_s;
    logic [DW-1:0]     x_tap_s;
    logic signed [ACCW-1:0] acc_nxt_s;

    assign accept_s    = (state_q == ST_IDLE) && start_i;
    assign handshake_s = (state_q == ST_OUT) && res_valid_q && res_ready_i;
    assign last_s      = (n_q == IW'(NEURONS-1));
    assign clr_s       = accept_s || handshake_s;
    // rd_* track the address issued last cycle, i.e. what w_data_i carries now
    assign tap_en_s    = rd_vld_q && (rd_k_q != K_BIAS);
    assign bias_en_s   = rd_vld_q && (rd_k_q == K_BIAS);
    assign x_tap_s     = (rd_k_q < K_BIAS) ? x_q[32'(rd_k_q)*DW +: DW] : '0;

    lyr1_mac_sequencer_tap_acc u_tap_acc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_s),
        .en_i       (tap_en_s),
        .add_bias_i (bias_en_s),
        .a_i        ($signed(x_tap_s)),
        .b_i        ($signed(w_data_i)),
        .acc_nxt_o  (acc_nxt_s)
    );

    // Sequencer next-state logic
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        n_d         = n_q;
        k_d         = k_q;
        w_en_d      = w_en_q;
        w_addr_d    = w_addr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_FETCH;
                    x_d      = x_flat_i;
                    n_d      = '0;
                    k_d      = 4'd0;
                    w_en_d   = 1'b1;
                    w_addr_d = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (k_q == K_BIAS) begin
                    state_d = ST_DRAIN;
                    w_en_d  = 1'b0;
                end else begin
                    k_d      = k_q + 4'd1;
                    w_addr_d = w_addr_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                // Bias lands this cycle; register the result from the post-bias sum
                state_d     = ST_OUT;
                res_valid_d = 1'b1;
                res_data_d  = sat_q88(acc_nxt_s);
                res_idx_d   = n_q;
            end
            ST_OUT: begin
                if (handshake_s) begin
                    res_valid_d = 1'b0;
                    n_d         = n_q + IW'(1);
                    if (last_s) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = ST_FETCH;
                        k_d      = 4'd0;
                        w_en_d   = 1'b1;
                        w_addr_d = w_addr_q + AW'(1);
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, window, counters and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            n_q         <= '0;
            k_q         <= 4'd0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_k_q      <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            n_q         <= n_d;
            k_q         <= k_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            rd_vld_q    <= w_en_q;
            rd_k_q      <= k_q;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign w_en_o      = w_en_q;
    assign w_addr_o    = w_addr_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_idx_o   = res_idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_lyr1_mac_sequencer.sv
// Directed testbench for lyr1_mac_sequencer with a 1-cycle-latency weight memory model.
module tb_lyr1_mac_sequencer;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [143:0]  x_flat;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_data;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_data;
    logic [IW-1:0] res_idx;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_base;

    logic [15:0]  mem [0:39];
    logic [15:0]  exp_res [0:3];
    logic [143:0] xw;
    logic [143:0] x_other;

    lyr1_mac_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .x_flat_i    (x_flat),
        .w_en_o      (w_en),
        .w_addr_o    (w_addr),
        .w_data_i    (w_data),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_idx_o   (res_idx),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) w_data <= mem[w_addr];
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int k, input logic [15:0] v);
        for (int n = 0; n < N; n++) mem[n*10+k] = v;
    endtask

    task automatic set_all(input logic [15:0] w, input logic [15:0] b);
        for (int k = 0; k < 9; k++) set_w(k, w);
        set_w(9, b);
    endtask

    task automatic set_x_all(input logic [15:0] v);
        for (int k = 0; k < 9; k++) xw[k*16 +: 16] = v;
    endtask

    task automatic do_start(input logic [143:0] x);
        @(negedge clk);
        x_flat = x;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        x_flat = {144{1'b1}};
    endtask

    // Collects N results; stall_idx selects a neuron held off for 20 cycles
    task automatic collect(input int stall_idx, input bit check_lat);
        int cyc;
        int t;
        cyc = 1;
        for (int i = 0; i < N; i++) begin
            res_ready = (i != stall_idx);
            t = 0;
            while (!res_valid && t < 40) begin
                @(negedge clk);
                cyc++;
                t++;
            end
            check("res_valid_seen", {31'd0, res_valid}, 32'd1);
            if (i == 0 && check_lat) check("first_latency", cyc, 32'd12);
            check("res_data", {16'd0, res_data}, {16'd0, exp_res[i]});
            check("res_idx", {30'd0, res_idx}, i);
            if (i == stall_idx) begin
                for (int s = 0; s < 20; s++) begin
                    @(negedge clk);
                    check("stall_valid", {31'd0, res_valid}, 32'd1);
                    check("stall_data", {16'd0, res_data}, {16'd0, exp_res[i]});
                    check("stall_idx", {30'd0, res_idx}, i);
                    check("stall_w_en", {31'd0, w_en}, 32'd0);
                end
                res_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (i < N-1) begin
                check("next_fetch_w_en", {31'd0, w_en}, 32'd1);
                check("next_fetch_addr", {26'd0, w_addr}, (i+1)*10);
                check("res_valid_drop", {31'd0, res_valid}, 32'd0);
            end else begin
                check("done_pulse", {31'd0, done}, 32'd1);
                check("busy_fall", {31'd0, busy}, 32'd0);
                @(negedge clk);
                check("done_clear", {31'd0, done}, 32'd0);
            end
        end
        res_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_en"}, {31'd0, w_en}, 32'd0);
        check({tag, "_w_addr"}, {26'd0, w_addr}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_res_data"}, {16'd0, res_data}, 32'd0);
        check({tag, "_res_idx"}, {30'd0, res_idx}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b1; x_flat = '0; xw = '0;
        for (int a = 0; a < 40; a++) mem[a] = 16'h0000;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // T1: 9 * (1.0 * 0.5) + 1.0 = 5.5
        set_x_all(16'h0100); set_all(16'h0080, 16'h0100);
        for (int i = 0; i < N; i++) exp_res[i] = 16'h0580;
        do_start(xw);
        check("t1_busy_rise", {31'd0, busy}, 32'd1);
        check("t1_w_en", {31'd0, w_en}, 32'd1);
        check("t1_w_addr0", {26'd0, w_addr}, 32'd0);
        collect(-1, 1'b1);

        // T2: 5*(4*0.25) + 4*(8*0.125) = 9.0
        for (int k = 0; k < 9; k++) begin
            xw[k*16 +: 16] = (k < 5) ? 16'h0400 : 16'h0800;
            set_w(k, (k < 5) ? 16'h0040 : 16'h0020);
        end
        set_w(9, 16'h0000);
        for (int i = 0; i < N; i++) exp_res[i] = 16'h0900;
        do_start(xw);
        collect(-1, 1'b1);

        // T3: positive and negative saturation
        set_x_all(16'h7FFF); set_all(16'h7FFF, 16'h0000);
        for (int i = 0; i < N; i++) exp_res[i] = 16'h7FFF;
        do_start(xw);
        collect(-1, 1'b0);
        set_all(16'h8000, 16'h0000);
        for (int i = 0; i < N; i++) exp_res[i] = 16'h8000;
        do_start(xw);
        collect(-1, 1'b0);

        // T4: consumer stall on neuron 1
        set_x_all(16'h0100); set_all(16'h0080, 16'h0100);
        for (int i = 0; i < N; i++) exp_res[i] = 16'h0580;
        do_start(xw);
        collect(1, 1'b1);

        // T5: start while busy with a different window is ignored
        for (int k = 0; k < 9; k++) x_other[k*16 +: 16] = 16'h0200;
        done_base = done_cnt;
        do_start(xw);
        repeat (3) @(negedge clk);
        x_flat = x_other; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(-1, 1'b0);
        repeat (5) @(negedge clk);
        check("t5_done_once", done_cnt - done_base, 32'd1);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_w_en", {31'd0, w_en}, 32'd0);

        // T6: asynchronous reset mid-FETCH, then a clean restart
        do_start(xw);
        repeat (3) @(negedge clk);
        check("t6_pre_w_en", {31'd0, w_en}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clk);
        rst = 1'b0;
        do_start(xw);
        collect(-1, 1'b1);

        // T7: per-neuron bias n*1.0 on top of 4.5 exercises neuron addressing
        for (int n = 0; n < N; n++) mem[n*10+9] = 16'(n * 256);
        exp_res[0] = 16'h0480; exp_res[1] = 16'h0580;
        exp_res[2] = 16'h0680; exp_res[3] = 16'h0780;
        do_start(xw);
        collect(-1, 1'b0);

        // T8: single tap -1/256 * (1/256) -> acc -1, shifted down toward -inf -> -1 LSB
        xw = '0; xw[15:0] = 16'hFFFF;
        set_all(16'h0000, 16'h0000); set_w(0, 16'h0001);
        for (int i = 0; i < N; i++) exp_res[i] = 16'hFFFF;
        do_start(xw);
        collect(-1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
